// File: rtl/crc_sram_loader.sv
// crc_sram_loader: accepts a valid/ready byte stream, packs bytes big-endian
// into 32-bit words and writes them to the shared SRAM at word-aligned byte
// addresses stepping by 4. Reports word/byte counts for the CRC pass.
//
// Byte handshake: a byte transfers on a rising edge where s_valid && s_ready.
// s_ready is high only in FILL; the source must hold s_data/s_last stable
// with s_valid high until that edge, and may drop s_valid at any time.
module crc_sram_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  sram_write_en,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-2:0] word_count,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Word-aligned mask; also equals the last word address (2^AW - 4).
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR   = ALIGN_MASK;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = 4;
  localparam logic [ADDR_WIDTH-2:0] WC_ONE     = 1;
  localparam logic [ADDR_WIDTH:0]   BC_ONE     = 1;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [1:0]              r_lane;
  logic                    r_last;
  logic                    r_overflow;
  logic [ADDR_WIDTH-2:0]   r_word_count;
  logic [ADDR_WIDTH:0]     r_byte_count;
  logic                    w_accept;
  logic                    w_at_top;

  assign w_accept = (r_state == S_FILL) && s_valid;
  assign w_at_top = (r_addr == TOP_ADDR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: a word closes on lane 3 or on the last byte.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_FILL;
      S_FILL:  if (w_accept && ((r_lane == 2'd3) || s_last)) w_next_state = S_WRITE;
      S_WRITE: begin
        if (r_last || w_at_top) w_next_state = S_DONE;
        else                    w_next_state = S_FILL;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: job setup, byte packing, address stepping, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_word       <= '0;
      r_lane       <= 2'd0;
      r_last       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
      r_byte_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr       <= base_addr & ALIGN_MASK;
            r_word       <= '0;
            r_lane       <= 2'd0;
            r_last       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
            r_byte_count <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            case (r_lane)
              2'd0:    r_word[DATA_WIDTH-1  -: 8] <= s_data;
              2'd1:    r_word[DATA_WIDTH-9  -: 8] <= s_data;
              2'd2:    r_word[DATA_WIDTH-17 -: 8] <= s_data;
              default: r_word[DATA_WIDTH-25 -: 8] <= s_data;
            endcase
            r_lane       <= r_lane + 2'd1;
            r_last       <= s_last;
            r_byte_count <= r_byte_count + BC_ONE;
          end
        end
        S_WRITE: begin
          r_word       <= '0;
          r_lane       <= 2'd0;
          r_word_count <= r_word_count + WC_ONE;
          // Without s_last, the top word ends the job as an overflow.
          if (!r_last) begin
            if (w_at_top) r_overflow <= 1'b1;
            else          r_addr     <= r_addr + ADDR_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_ready       = (r_state == S_FILL);
  assign sram_write_en = (r_state != S_WRITE);
  assign sram_address  = r_addr;
  assign sram_data_in  = r_word;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign overflow      = r_overflow;
  assign word_count    = r_word_count;
  assign byte_count    = r_byte_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_crc_sram_loader.sv
// Testbench for crc_sram_loader: directed jobs, expected SRAM writes and
// completion reports pushed into queues, checked by a negedge monitor.
module tb_crc_sram_loader;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int W  = AW + DW;            // {addr, data} per write
  localparam int RW = 1 + (AW - 1) + (AW + 1); // {overflow, word_count, byte_count}

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;
  logic          sram_write_en;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_data_in;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW-2:0] word_count;
  logic [AW:0]   byte_count;
  logic [1:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [RW-1:0] exp_done_q[$];

  int checks = 0;
  int errors = 0;

  crc_sram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .sram_write_en(sram_write_en), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .busy(busy), .done(done),
    .overflow(overflow), .word_count(word_count), .byte_count(byte_count),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe and done pulse is matched against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sram_write_en === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 sram_address, sram_data_in);
      end else begin
        chk("write", {sram_address, sram_data_in}, exp_q.pop_front());
      end
    end
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        chk("done_report", {overflow, word_count, byte_count}, exp_done_q.pop_front());
      end
    end
  end

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_done(input logic ov, input int wc, input int bc);
    logic [AW-2:0] w;
    logic [AW:0]   b;
    w = wc[AW-2:0];
    b = bc[AW:0];
    exp_done_q.push_back({ov, w, b});
  endtask

  // Pulse start for one cycle; returns at posedge+1.
  task automatic do_start(input logic [AW-1:0] a);
    @(negedge clk);
    base_addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and wait (bounded) for acceptance; returns at posedge+1.
  // ends_word: the accepting edge must be followed by the write strobe.
  task automatic send_byte(input logic [7:0] d, input logic l, input logic ends_word,
                           input logic pulse_start);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    if (pulse_start) start = 1'b1;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got s_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    if (ends_word) chk("strobe_latency", sram_write_en, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    sram_write_en, 1'b1);
    chk({tag, "_addr"},  sram_address, '0);
    chk({tag, "_data"},  sram_data_in, '0);
    chk({tag, "_ready"}, s_ready, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
    chk({tag, "_ovf"},   overflow, 1'b0);
    chk({tag, "_wc"},    word_count, '0);
    chk({tag, "_bc"},    byte_count, '0);
    chk({tag, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word.
    push_write(11'h000, 32'hBABECAFE);
    push_done(1'b0, 1, 4);
    do_start(11'h000);
    send_byte(8'hBA, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0, 1'b0);
    send_byte(8'hCA, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFE, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // 2: unaligned base, partial trailing word.
    push_write(11'h010, 32'h01020304);
    push_write(11'h014, 32'h05000000);
    push_done(1'b0, 2, 5);
    do_start(11'h013);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // 3: as case 2 with a 3-cycle s_valid gap; s_ready stays high in the gap.
    push_write(11'h010, 32'h01020304);
    push_write(11'h014, 32'h05000000);
    push_done(1'b0, 2, 5);
    do_start(11'h013);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_ready", s_ready, 1'b1);
    end
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // 4: top of SRAM reached without s_last.
    push_write(11'h7FC, 32'h11223344);
    push_done(1'b1, 1, 4);
    do_start(11'h7FC);
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1, 1'b0);
    s_valid = 1'b1; s_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_no_accept", s_ready, 1'b0);
    end
    s_valid = 1'b0;
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_bc_hold", byte_count, 12'd4);

    // 5: reset in the middle of a job, then a clean job at 0x020.
    do_start(11'h040);
    send_byte(8'hA1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_write(11'h020, 32'hBABECAFE);
    push_done(1'b0, 1, 4);
    do_start(11'h020);
    send_byte(8'hBA, 1'b0, 1'b0, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0, 1'b0);
    send_byte(8'hCA, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFE, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // 6: start pulsed during FILL is ignored.
    push_write(11'h100, 32'h01020304);
    push_write(11'h104, 32'h05000000);
    push_done(1'b0, 2, 5);
    do_start(11'h100);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b0, 1'b1);
    send_byte(8'h04, 1'b0, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b1, 1'b0);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("writes_left", exp_q.size(), 0);
    chk("dones_left", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_sram_loader.md
Name: crc_sram_loader

Overview:
- Upstream feeder for the CRC/SRAM top.
- Accepts a valid/ready byte stream and packs bytes big-endian into 32-bit words.
- Writes each word into the shared SRAM at word-aligned byte addresses stepping by 4.
- Reports word and byte counts so the downstream CRC pass knows the message extent.

Parameters:
- ADDR_WIDTH, 11, SRAM byte-address width.
- DATA_WIDTH, 32, SRAM word width. Packing logic is fixed at 4 bytes per word.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start; honoured only in IDLE
- base_addr  in  ADDR_WIDTH  first write address; bits [1:0] forced to 0 when latched
- s_valid  in  1  byte valid
- s_ready  out  1  byte accepted when s_valid && s_ready
- s_data  in  8  stream byte
- s_last  in  1  marks final byte of message; sampled with the byte
- sram_write_en  out  1  SRAM write strobe, active low (0 = write)
- sram_address  out  ADDR_WIDTH  SRAM byte address
- sram_data_in  out  DATA_WIDTH  packed word
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky until next start; SRAM top reached before s_last
- word_count  out  ADDR_WIDTH-1  words written in the current/last job
- byte_count  out  ADDR_WIDTH+1  bytes accepted in the current/last job

Behaviour:
- Reset (async assert, sync deassert handled by the top):
  - state=IDLE, sram_write_en=1, sram_address=0, sram_data_in=0.
  - s_ready=0, busy=0, done=0, overflow=0, counts=0.
  - Byte lane index=0. A partially packed word is discarded; no write is issued.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - s_ready=0.
  - start=1: latch {base_addr[AW-1:2],2'b00} into the address register, clear word_count, byte_count, overflow and the packing register (zero-filled), lane=0, then go to FILL.
- FILL:
  - s_ready=1.
  - On each accepted byte, place it at lane position: lane0 -> [31:24], lane1 -> [23:16], lane2 -> [15:8], lane3 -> [7:0]. Then byte_count++ and lane++.
  - Go to WRITE when the byte is lane3 or s_last=1. Latch the last flag.
  - Cycles with s_valid=0 hold state; there is no timeout.
- WRITE (exactly one cycle):
  - s_ready=0, sram_write_en=0, sram_address=current address, sram_data_in=packed word. Unfilled lanes are 0.
  - word_count++.
  - Next cycle: sram_write_en=1, packing register cleared, lane=0.
  - If the last flag is set: go to DONE.
  - Else, if the address equals 2^AW-4: set overflow=1 and go to DONE.
  - Else: address += 4 and go to FILL.
- DONE: done=1 for one cycle, s_ready=0, then go to IDLE. Counts and overflow hold until the next start.
- start outside IDLE is ignored.
- s_valid in IDLE/WRITE/DONE is not accepted; the source must hold the byte.
- Throughput: 4 bytes per 5 cycles with s_valid continuously high.
- Latency: write strobe appears 1 cycle after the accepting edge of the 4th or last byte.
- Maximum job: 2^(AW-2) words from base 0, i.e. 512 words / 2048 bytes at AW=11. Counter widths hold these maxima without wrap.
- After overflow the byte stream is not drained. Upstream must abort or restart.

Test Plan:
1. start, base_addr=0x000; bytes BA,BE,CA,FE with s_last on FE -> one strobe: sram_write_en=0, address 0x000, data 0xBABECAFE; done pulse; word_count=1, byte_count=4, overflow=0.
2. base_addr=0x013; bytes 01..05, s_last on 05 -> writes 0x01020304 @0x010, then 0x05000000 @0x014; word_count=2, byte_count=5.
3. Case 2 stream with s_valid low for 3 cycles between bytes 2 and 3 -> same two writes and counts; s_ready=0 only during the WRITE/DONE cycles; no duplicated or dropped bytes.
4. base_addr=0x7FC; bytes 11,22,33,44,55, no s_last -> single write 0x11223344 @0x7FC; overflow=1, done pulse; byte 55 not accepted (s_ready=0); word_count=1, byte_count=4.
5. Assert rst_n low after 2 bytes of a job -> all outputs at reset values immediately; no sram_write_en=0 cycle ever issued; a following job at base 0x020 behaves as case 1.
6. start pulsed during FILL of a job -> ignored; address/count sequence identical to the no-pulse run.
